// File: rtl/ysyx_23060184_lsu_pkg.sv
// rtl/ysyx_23060184_lsu_pkg.sv - shared codes for the load/store unit
package ysyx_23060184_defines;

  // access size codes
  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HALF  = 2'd1;
  localparam logic [1:0] SIZE_WORD  = 2'd2;
  localparam logic [1:0] SIZE_DWORD = 2'd3;

  // fault cause codes reported to write-back
  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_SLVERR   = 2'd2;
  localparam logic [1:0] CAUSE_DECERR   = 2'd3;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  // shared arbiter: grant vector width and the code owned by the data memory port
  localparam int                         NUM_ARB_MASTERS = 2;
  localparam logic [NUM_ARB_MASTERS-1:0] DATAMEM_GRANT   = 2'b10;

  // OKAY and EXOKAY are both successful completions
  function automatic logic [1:0] resp_to_cause(input logic [1:0] resp);
    case (resp)
      RESP_SLVERR: return CAUSE_SLVERR;
      RESP_DECERR: return CAUSE_DECERR;
      default:     return CAUSE_NONE;
    endcase
  endfunction

  // true when the low address bits are not a multiple of the access size
  function automatic logic is_misaligned(input logic [2:0] low_addr, input logic [1:0] sz);
    case (sz)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return low_addr[0];
      SIZE_WORD: return |low_addr[1:0];
      default:   return |low_addr;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060184_lsu_align.sv
// rtl/ysyx_23060184_lsu_align.sv - byte-lane store shifter/strobes and load extractor/extender
module ysyx_23060184_lsu_align
  import ysyx_23060184_defines::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int STRB_W     = DATA_WIDTH / 8,
  localparam int OFF_W      = $clog2(STRB_W)
) (
  input  logic [OFF_W-1:0]      offset,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_W-1:0]     wstrb,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [OFF_W+2:0]      bit_shift;
  logic [STRB_W-1:0]     base_strb;
  logic [DATA_WIDTH-1:0] lane_data;
  logic                  sign_bit;

  assign bit_shift = {offset, 3'b000};
  assign wdata     = store_data << bit_shift;
  assign wstrb     = base_strb << offset;
  assign lane_data = rdata >> bit_shift;

  // one strobe bit per byte of the access, before moving it to its lane
  always_comb begin
    base_strb = '0;
    for (int i = 0; i < STRB_W; i++) begin
      base_strb[i] = (i < (1 << size));
    end
  end

  // keep the accessed bytes and fill the rest with the sign bit or zero
  always_comb begin
    case (size)
      SIZE_BYTE: sign_bit = lane_data[7];
      SIZE_HALF: sign_bit = lane_data[15];
      default:   sign_bit = lane_data[31];
    endcase
    load_data = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < (8 << size)) begin
        load_data[i] = lane_data[i];
      end else begin
        load_data[i] = sign_bit & ~is_unsigned;
      end
    end
  end

endmodule

// File: rtl/ysyx_23060184_lsu.sv
// rtl/ysyx_23060184_lsu.sv - load/store unit with a single AXI4-Lite master port
module ysyx_23060184_lsu
  import ysyx_23060184_defines::*;
#(
  parameter  int                     DATA_WIDTH  = 32,  // 32 or 64
  parameter  int                     ADDR_WIDTH  = 32,
  parameter  int                     NUM_MASTERS = NUM_ARB_MASTERS,
  parameter  logic [NUM_MASTERS-1:0] GRANT_ID    = DATAMEM_GRANT,
  localparam int                     STRB_W      = DATA_WIDTH / 8,
  localparam int                     OFF_W       = $clog2(STRB_W)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   e_valid,
  output logic                   m_ready,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [1:0]             size,
  input  logic                   is_unsigned,
  input  logic [DATA_WIDTH-1:0]  store_data,
  output logic                   m_valid,
  input  logic                   w_ready,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   fault,
  output logic [1:0]             fault_cause,
  output logic                   req,
  input  logic [NUM_MASTERS-1:0] grant,
  output logic [ADDR_WIDTH-1:0]  araddr,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [DATA_WIDTH-1:0]  rdata,
  input  logic [1:0]             rresp,
  input  logic                   rvalid,
  output logic                   rready,
  output logic [ADDR_WIDTH-1:0]  awaddr,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [DATA_WIDTH-1:0]  wdata,
  output logic [STRB_W-1:0]      wstrb,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_RADDR = 3'd2;
  localparam logic [2:0] S_RDATA = 3'd3;
  localparam logic [2:0] S_WREQ  = 3'd4;
  localparam logic [2:0] S_WRESP = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  read_q;
  logic [DATA_WIDTH-1:0] sdata_q;

  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [STRB_W-1:0]     lane_wstrb;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  aw_done;
  logic                  w_done;

  assign m_ready  = (state == S_IDLE);
  assign m_valid  = (state == S_DONE);
  assign bus_addr = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  // a channel counts as done once its valid has dropped or is handshaking now
  assign aw_done = ~awvalid | awready;
  assign w_done  = ~wvalid | wready;

  ysyx_23060184_lsu_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .offset      (addr_q[OFF_W-1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .store_data  (sdata_q),
    .rdata       (rdata),
    .wdata       (lane_wdata),
    .wstrb       (lane_wstrb),
    .load_data   (load_data)
  );

  // operation FSM; every bus output is registered so valids never follow readies combinationally
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      size_q      <= SIZE_BYTE;
      uns_q       <= 1'b0;
      read_q      <= 1'b0;
      sdata_q     <= '0;
      result      <= '0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
      req         <= 1'b0;
      araddr      <= '0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      awaddr      <= '0;
      awvalid     <= 1'b0;
      wdata       <= '0;
      wstrb       <= '0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (e_valid && m_ready) begin
            addr_q      <= addr;
            size_q      <= size;
            uns_q       <= is_unsigned;
            read_q      <= mem_read;
            sdata_q     <= store_data;
            result      <= '0;
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
            if (!mem_read && !mem_write) begin
              state <= S_DONE;
            end else if (is_misaligned(addr[2:0], size)) begin
              fault       <= 1'b1;
              fault_cause <= CAUSE_MISALIGN;
              state       <= S_DONE;
            end else begin
              req   <= 1'b1;
              state <= S_ARB;
            end
          end
        end
        S_ARB: begin
          if (grant == GRANT_ID) begin
            if (read_q) begin
              araddr  <= bus_addr;
              arvalid <= 1'b1;
              state   <= S_RADDR;
            end else begin
              awaddr  <= bus_addr;
              wdata   <= lane_wdata;
              wstrb   <= lane_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= S_WREQ;
            end
          end
        end
        S_RADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (rvalid) begin
            rready      <= 1'b0;
            req         <= 1'b0;
            result      <= load_data;
            fault       <= (resp_to_cause(rresp) != CAUSE_NONE);
            fault_cause <= resp_to_cause(rresp);
            state       <= S_DONE;
          end
        end
        S_WREQ: begin
          if (aw_done && w_done) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b1;
            state   <= S_WRESP;
          end else begin
            if (awready) awvalid <= 1'b0;
            if (wready)  wvalid  <= 1'b0;
          end
        end
        S_WRESP: begin
          if (bvalid) begin
            bready      <= 1'b0;
            req         <= 1'b0;
            fault       <= (resp_to_cause(bresp) != CAUSE_NONE);
            fault_cause <= resp_to_cause(bresp);
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ysyx_23060184_lsu.md
# ysyx_23060184_lsu

Parametrised load/store unit between the execute and write-back stages. It replaces the fixed SRAM/UART data-memory block with a single AXI4-Lite master port, driven by a state machine and routed by the downstream crossbar. It adds byte-lane alignment, sub-word store strobes, misalignment detection and bus-error reporting. Bus access goes through the shared arbiter using a request/grant pair.

## Interface
- DATA_WIDTH, 32: data bus width; must be 32 or 64.
- ADDR_WIDTH, 32: address width.
- GRANT_ID, `DATAMEM_GRANT`: arbiter grant code owned by this unit.
- NUM_MASTERS, `NUM_ARB_MASTERS`: width of the grant vector.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- e_valid  in  1  execute result valid.
- m_ready  out  1  LSU can accept an operation.
- mem_read / mem_write  in  1 / 1  operation kind; both low means pass-through.
- addr  in  ADDR_WIDTH  effective address.
- size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_WIDTH is 64).
- is_unsigned  in  1  zero-extend loads instead of sign-extending.
- store_data  in  DATA_WIDTH  store data, right-aligned.
- m_valid  out  1  result valid to write-back.
- w_ready  in  1  write-back accepts the result.
- result  out  DATA_WIDTH  extended load data; 0 for stores and pass-through.
- fault  out  1  the operation ended in error; qualified by m_valid.
- fault_cause  out  2  1 = misaligned, 2 = SLVERR, 3 = DECERR.
- req  out  1  bus request to the arbiter.
- grant  in  NUM_MASTERS  arbiter grant vector.
- araddr, arvalid, arready: AXI read address channel.
- rdata, rresp, rvalid, rready: AXI read data channel; rresp is 2 bits.
- awaddr, awvalid, awready: AXI write address channel.
- wdata, wstrb, wvalid, wready: AXI write data channel; wstrb is DATA_WIDTH/8 bits.
- bresp, bvalid, bready: AXI write response channel; bresp is 2 bits.

## Operation
- States: IDLE, ARB, RADDR, RDATA, WREQ, WRESP, DONE.
- Input capture: in IDLE, when e_valid && m_ready, latch addr, size, is_unsigned, kind and store_data. m_ready is high only in IDLE.
- Pass-through (no read, no write): go to DONE with result 0 and fault 0.
- Misalignment: an address not aligned to 2^size goes straight to DONE with fault=1, cause=1. No bus activity and no req.
- Otherwise go to ARB and assert req. On grant==GRANT_ID, move to RADDR for a load or WREQ for a store.
- req stays high until the response handshake completes. The arbiter holds grant for that whole time.
- RADDR: arvalid=1, araddr = addr with its low log2(DATA_WIDTH/8) bits cleared. On arready, go to RDATA.
- RDATA: rready=1. On rvalid, shift rdata right by 8 × byte offset, then sign- or zero-extend per size and is_unsigned. Latch the result; a nonzero rresp latches the fault. Go to DONE.
- WREQ: awvalid and wvalid rise together.
  - wdata = store_data shifted left by 8 × byte offset.
  - wstrb = ((1 << 2^size) − 1) << offset.
  - Each valid drops independently on its own handshake. Go to WRESP when both channels have handshaken, including the case where both handshake in the same cycle.
- WRESP: bready=1. On bvalid, latch bresp → fault and go to DONE.
- DONE: m_valid=1; result and fault stay stable. On w_ready, return to IDLE.
- Fault cause mapping: rresp/bresp 2 → cause 2, 3 → cause 3, 0/1 → no fault.

## Timing
- Reset values: state IDLE; m_ready=1; all other outputs 0 (m_valid, fault, fault_cause, result, req, arvalid, rready, awvalid, wvalid, bready, wstrb, wdata, araddr, awaddr).
- Pass-through or misaligned operation: m_valid rises 1 cycle after acceptance.
- Load latency with zero-wait slave and immediate grant: accept → ARB → RADDR → RDATA → DONE, so m_valid rises 4 cycles after acceptance.
- AXI compliance:
  - Once a valid is asserted, it and its payload stay stable until the handshake.
  - Valid never depends combinationally on ready.
  - rvalid or bvalid arriving in the same cycle as the entry into RDATA or WRESP is accepted, because rready/bready are registered high on that entry.
- Asserting resetn low mid-transaction returns the block to IDLE immediately. Bus-side cleanup is the interconnect's responsibility, since the system resets together.
- m_valid held with w_ready low: state and outputs frozen indefinitely.

## Structure
- Shared package/header (`ysyx_23060184_defines`) holds:
  - size codes;
  - fault cause codes;
  - AXI resp codes (OKAY, EXOKAY, SLVERR, DECERR);
  - DATAMEM_GRANT and NUM_ARB_MASTERS.
- One sub-module, ysyx_23060184_lsu_align: combinational store-lane shifter and strobe generator, plus load extractor and extender, parametrised by DATA_WIDTH. The FSM stays in the top module.

## Test plan
1. Load word at 0x8000_0004, rdata=0xDEAD_BEEF, rresp=0 → result 0xDEADBEEF, fault 0, m_valid 4 cycles after acceptance.
2. Load byte, signed, at 0x8000_0003 with rdata=0x80_00_00_00 → result 0xFFFF_FF80. Same access with is_unsigned → 0x0000_0080.
3. Store half 0x1234 at 0x8000_0002 → wdata=0x1234_0000 and wstrb=0b1100. Run twice: once with awready 3 cycles before wready, once with both in the same cycle. Both runs get a single WRESP entry, m_valid after bvalid, and fault 0.
4. Load word at 0x8000_0002 → no req and no arvalid; fault=1, cause=1, m_valid 1 cycle after acceptance.
5. Store with bresp=3 (DECERR), grant delayed 5 cycles → req held and awvalid low until grant; result is fault=1, cause=3.
6. Reset asserted while in RDATA → all outputs at reset values asynchronously. The next load after reset completes normally; w_ready held low for 10 cycles keeps m_valid and result stable.
